// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage definitions: word width, instruction memory size, NOP encoding,
// the IF/ID register contents and the address wrap helper.
package instruction_fetch_pkg;

   localparam int unsigned WORD_LEN       = 32;
   localparam int unsigned INSTR_MEM_SIZE = 1024;

   typedef logic [WORD_LEN-1:0] word_t;

   localparam word_t NOP = '0;

   typedef struct packed {
      word_t instr;
      word_t pc;
      word_t pc_plus4;
      logic  valid;
   } if_id_t;

   typedef enum logic [1:0] {
      IFID_CAPTURE,
      IFID_HOLD,
      IFID_BUBBLE
   } if_id_action_e;

   // Byte addresses into instruction memory wrap modulo its size.
   function automatic word_t mem_wrap(input word_t addr);
      return addr % word_t'(INSTR_MEM_SIZE);
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble (flush) beats hold (stall) beats capture.
module if_id_reg
   import instruction_fetch_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                flush,
   input  logic [WORD_LEN-1:0] instr,
   input  logic [WORD_LEN-1:0] pc,
   input  logic [WORD_LEN-1:0] pc_plus4,
   output logic [WORD_LEN-1:0] id_instr,
   output logic [WORD_LEN-1:0] id_pc,
   output logic [WORD_LEN-1:0] id_pc_plus4,
   output logic                id_valid,
   output logic                capture
);

   if_id_action_e action;
   if_id_t        q;

   always_comb begin
      action = IFID_CAPTURE;
      if (flush)
         action = IFID_BUBBLE;
      else if (stall)
         action = IFID_HOLD;
   end

   // A bubble keeps the old PC fields; only the instruction and valid are killed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= '0;
      end else begin
         case (action)
            IFID_CAPTURE: q <= '{instr: instr, pc: pc, pc_plus4: pc_plus4, valid: 1'b1};
            IFID_BUBBLE: begin
               q.instr <= NOP;
               q.valid <= 1'b0;
            end
            default: q <= q;
         endcase
      end
   end

   assign capture     = (action == IFID_CAPTURE);
   assign id_instr    = q.instr;
   assign id_pc       = q.pc;
   assign id_pc_plus4 = q.pc_plus4;
   assign id_valid    = q.valid;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register with redirect/stall priority, IF/ID register
// and a count of instructions accepted into IF/ID.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [WORD_LEN-1:0] RESET_PC = '0,
   parameter int unsigned         PC_STEP  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                flush,
   input  logic                branch_taken,
   input  logic [WORD_LEN-1:0] branch_target,
   output logic [WORD_LEN-1:0] imem_addr,
   input  logic [WORD_LEN-1:0] imem_instr,
   output logic [WORD_LEN-1:0] id_instr,
   output logic [WORD_LEN-1:0] id_pc,
   output logic [WORD_LEN-1:0] id_pc_plus4,
   output logic                id_valid,
   output logic [WORD_LEN-1:0] fetch_count
);

   word_t pc;
   word_t pc_next;
   word_t pc_plus_step;
   word_t redirect_pc;
   logic  capture;

   assign pc_plus_step = pc + word_t'(PC_STEP);
   assign redirect_pc  = mem_wrap({branch_target[WORD_LEN-1:2], 2'b00});

   always_comb begin
      pc_next = mem_wrap(pc_plus_step);
      if (branch_taken)
         pc_next = redirect_pc;
      else if (stall)
         pc_next = pc;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         pc <= RESET_PC;
      else
         pc <= pc_next;
   end

   assign imem_addr = pc;

   // A taken branch squashes the wrong-path instruction exactly like a flush.
   if_id_reg u_if_id_reg (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .flush       (flush | branch_taken),
      .instr       (imem_instr),
      .pc          (pc),
      .pc_plus4    (pc_plus_step),
      .id_instr    (id_instr),
      .id_pc       (id_pc),
      .id_pc_plus4 (id_pc_plus4),
      .id_valid    (id_valid),
      .capture     (capture)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         fetch_count <= '0;
      else if (capture)
         fetch_count <= fetch_count + word_t'(1);
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed steps queue hand-computed
// expectations, a monitor compares them at the matching falling edge.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = '0;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
   logic        id_valid;
   logic [31:0] fetch_count;

   typedef struct {
      int          cyc;
      bit          now;
      string       name;
      logic [31:0] addr;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pp4;
      logic [31:0] fc;
      logic        v;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   event chk_ev;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return 32'hE000_0000 | a;
   endfunction

   assign imem_instr = instr_of(imem_addr);

   instruction_fetch #(.RESET_PC(32'h0), .PC_STEP(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .flush         (flush),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_addr     (imem_addr),
      .imem_instr    (imem_instr),
      .id_instr      (id_instr),
      .id_pc         (id_pc),
      .id_pc_plus4   (id_pc_plus4),
      .id_valid      (id_valid),
      .fetch_count   (fetch_count)
   );

   task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s.%s actual=%h expected=%h", nm, fld, act, exp);
      end
   endtask

   task automatic compare(input exp_t e);
      chk(e.name, "imem_addr",   imem_addr,            e.addr);
      chk(e.name, "id_instr",    id_instr,             e.instr);
      chk(e.name, "id_pc",       id_pc,                e.pc);
      chk(e.name, "id_pc_plus4", id_pc_plus4,          e.pp4);
      chk(e.name, "id_valid",    {31'b0, id_valid},    {31'b0, e.v});
      chk(e.name, "fetch_count", fetch_count,          e.fc);
   endtask

   // Monitor: clocked expectations at the falling edge, reset expectations on demand.
   initial begin
      forever begin
         @(negedge clk or chk_ev);
         while (sb.size() > 0 && (sb[0].now || sb[0].cyc <= cyc))
            compare(sb.pop_front());
      end
   end

   task automatic step(input string nm, input bit st, input bit fl, input bit br,
                       input logic [31:0] tgt, input logic [31:0] e_addr,
                       input logic [31:0] e_pc, input logic [31:0] e_pp4,
                       input bit e_v, input logic [31:0] e_fc);
      exp_t e;
      stall = st;
      flush = fl;
      branch_taken = br;
      branch_target = tgt;
      e.cyc = cyc + 1;
      e.now = 1'b0;
      e.name = nm;
      e.addr = e_addr;
      e.instr = e_v ? instr_of(e_pc) : 32'h0;
      e.pc = e_pc;
      e.pp4 = e_pp4;
      e.fc = e_fc;
      e.v = e_v;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic reset_chk(input string nm);
      exp_t e;
      e.cyc = cyc;
      e.now = 1'b1;
      e.name = nm;
      e.addr = 32'h0;
      e.instr = 32'h0;
      e.pc = 32'h0;
      e.pp4 = 32'h0;
      e.fc = 32'h0;
      e.v = 1'b0;
      sb.push_back(e);
      ->chk_ev;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      reset_chk("reset_state");
      @(negedge clk);
      rst = 1'b1;

      //    name          st fl br target        addr          id_pc         pp4           v  fc
      step("seq0",        0, 0, 0, 32'h0,        32'h4,        32'h0,        32'h4,        1, 1);
      step("seq1",        0, 0, 0, 32'h0,        32'h8,        32'h4,        32'h8,        1, 2);
      step("stall0",      1, 0, 0, 32'h0,        32'h8,        32'h4,        32'h8,        1, 2);
      step("stall1",      1, 0, 0, 32'h0,        32'h8,        32'h4,        32'h8,        1, 2);
      step("stall2",      1, 0, 0, 32'h0,        32'h8,        32'h4,        32'h8,        1, 2);
      step("resume",      0, 0, 0, 32'h0,        32'hC,        32'h8,        32'hC,        1, 3);
      step("seq2",        0, 0, 0, 32'h0,        32'h10,       32'hC,        32'h10,       1, 4);
      step("br_stall",    1, 0, 1, 32'h23,       32'h20,       32'hC,        32'h10,       0, 4);
      step("br_land",     0, 0, 0, 32'h0,        32'h24,       32'h20,       32'h24,       1, 5);
      step("br_big",      0, 0, 1, 32'h417,      32'h14,       32'h20,       32'h24,       0, 5);
      step("big_land",    0, 0, 0, 32'h0,        32'h18,       32'h14,       32'h18,       1, 6);
      step("flush",       0, 1, 0, 32'h0,        32'h1C,       32'h14,       32'h18,       0, 6);
      step("post_flush",  0, 0, 0, 32'h0,        32'h20,       32'h1C,       32'h20,       1, 7);
      step("flush_stall", 1, 1, 0, 32'h0,        32'h20,       32'h1C,       32'h20,       0, 7);
      step("post_fs",     0, 0, 0, 32'h0,        32'h24,       32'h20,       32'h24,       1, 8);
      step("br_top",      0, 0, 1, 32'h3F0,      32'h3F0,      32'h20,       32'h24,       0, 8);
      step("top0",        0, 0, 0, 32'h0,        32'h3F4,      32'h3F0,      32'h3F4,      1, 9);
      step("top1",        0, 0, 0, 32'h0,        32'h3F8,      32'h3F4,      32'h3F8,      1, 10);
      step("top2",        0, 0, 0, 32'h0,        32'h3FC,      32'h3F8,      32'h3FC,      1, 11);
      step("wrap",        0, 0, 0, 32'h0,        32'h0,        32'h3FC,      32'h400,      1, 12);
      step("after_wrap",  0, 0, 0, 32'h0,        32'h4,        32'h0,        32'h4,        1, 13);

      // Mid-run asynchronous reset with a redirect, stall and flush all pending.
      stall = 1'b1;
      flush = 1'b1;
      branch_taken = 1'b1;
      branch_target = 32'h100;
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      reset_chk("async_reset");
      repeat (2) @(posedge clk);
      #1;
      reset_chk("reset_hold");
      @(negedge clk);
      stall = 1'b0;
      flush = 1'b0;
      branch_taken = 1'b0;
      branch_target = '0;
      rst = 1'b1;
      step("rel0",        0, 0, 0, 32'h0,        32'h4,        32'h0,        32'h4,        1, 1);
      step("rel1",        0, 0, 0, 32'h0,        32'h8,        32'h4,        32'h8,        1, 2);

      for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain actual=%0d pending expected=0 pending", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 0, byte address loaded into the PC on reset.
REQ-002 Parameter PC_STEP, default 4, byte increment per sequential fetch.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  hold request from the hazard detection unit; freezes PC and IF/ID.
REQ-006 flush  input  1  kill the instruction currently in IF/ID (bubble insertion).
REQ-007 branch_taken  input  1  redirect request from the branch-resolution stage.
REQ-008 branch_target  input  WORD_LEN  redirect byte address.
REQ-009 imem_addr  output  WORD_LEN  byte address driven to the combinational instruction memory.
REQ-010 imem_instr  input  WORD_LEN  big-endian instruction word returned from imem_addr, same cycle.
REQ-011 id_instr  output  WORD_LEN  IF/ID registered instruction.
REQ-012 id_pc  output  WORD_LEN  IF/ID registered PC of id_instr.
REQ-013 id_pc_plus4  output  WORD_LEN  IF/ID registered id_pc + PC_STEP, for link/branch use.
REQ-014 id_valid  output  1  IF/ID holds a real instruction (0 = bubble).
REQ-015 fetch_count  output  WORD_LEN  number of instructions accepted into IF/ID since reset.

Function
REQ-016 imem_addr SHALL equal the PC register combinationally; fetch latency PC-to-id_instr is exactly one cycle.
REQ-017 PC next-state priority SHALL be: branch_taken > stall > sequential (PC + PC_STEP).
REQ-018 On branch_taken, PC SHALL load {branch_target[WORD_LEN-1:2], 2'b00} regardless of stall.
REQ-019 Sequential PC SHALL wrap modulo INSTR_MEM_SIZE: PC = INSTR_MEM_SIZE-PC_STEP advances to 0.
REQ-020 A redirect target >= INSTR_MEM_SIZE SHALL be reduced modulo INSTR_MEM_SIZE before loading.
REQ-021 IF/ID next-state priority SHALL be: (flush or branch_taken) > stall > capture.
REQ-022 On flush or branch_taken, IF/ID SHALL load id_instr=0 (NOP), id_valid=0, id_pc and id_pc_plus4 unchanged.
REQ-023 On stall without flush/branch_taken, all IF/ID fields SHALL hold.
REQ-024 On capture, IF/ID SHALL load imem_instr, PC, PC+PC_STEP (unwrapped sum), id_valid=1.
REQ-025 fetch_count SHALL increment by 1 exactly on capture cycles; wraps at 2^WORD_LEN; never counts bubbles or stalls.
REQ-026 flush with stall SHALL produce a bubble and freeze the PC (stall still governs PC).
REQ-027 First cycle after reset release SHALL capture the instruction at RESET_PC.

Reset
REQ-028 While rst=0, asynchronously: PC=RESET_PC, id_instr=0, id_pc=0, id_pc_plus4=0, id_valid=0, fetch_count=0.
REQ-029 Reset asserted mid-operation SHALL discard any pending redirect, stall or flush; no state survives.
REQ-030 Reset release SHALL be clean with respect to clk; no input is sampled during rst=0.

Structure
REQ-031 WORD_LEN, INSTR_MEM_SIZE and the NOP encoding (all zeros) SHALL come from the shared defines.sv; no local redefinition.
REQ-032 The IF/ID register (fields, valid, stall/flush priority) SHALL be a sub-module named if_id_reg; PC logic and counter stay in instruction_fetch.

Verification
REQ-033 Reset release, no stall: imem_addr 0,4,8,12 on consecutive cycles; id_pc lags by one; fetch_count=3 after 4 cycles.
REQ-034 stall held 3 cycles at PC=8: imem_addr stays 8, id_instr/id_pc frozen, fetch_count unchanged; resumes with 12.
REQ-035 branch_taken with target 0x23 at PC=16 (stall=1 same cycle): next PC=0x20, id_valid=0, id_instr=0; next cycle id_pc=0x20.
REQ-036 Sequential run to PC=INSTR_MEM_SIZE-4: next imem_addr=0, id_pc_plus4=INSTR_MEM_SIZE.
REQ-037 flush alone at PC=24: id_valid=0, PC advances to 28; fetch_count not incremented that cycle.
REQ-038 rst driven low between clock edges mid-run: outputs and PC go to reset values immediately, no edge required.
